// File: rtl/mips_pkg.sv
// Shared constants and loader state encoding for the data-memory loader slice.
package mips_pkg;

    localparam int unsigned MEM_DEPTH = 256;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned DATA_W    = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } loader_state_t;

endpackage

// File: rtl/data_mem_loader_byte_packer.sv
// Little-endian byte-to-word assembler: byte k of a word lands in bits [8k+7:8k].
module byte_packer #(
    parameter int unsigned DATA_W = mips_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        byte_data,
    output logic [DATA_W-1:0] word_next_c,
    output logic              last_c
);
    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [IDX_W-1:0]  byte_idx;
    logic [DATA_W-1:0] word_q;

    // Word as it stands once the byte on byte_data is inserted.
    always_comb begin
        word_next_c = word_q;
        word_next_c[{byte_idx, 3'b000} +: 8] = byte_data;
    end

    assign last_c = (byte_idx == IDX_W'(NBYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx <= '0;
            word_q   <= '0;
        end else if (clear) begin
            byte_idx <= '0;
            word_q   <= '0;
        end else if (accept) begin
            word_q   <= word_next_c;
            byte_idx <= last_c ? '0 : byte_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/data_mem_loader.sv
// Streams bytes into data memory as little-endian words, holding the CPU off memory while busy.
module data_mem_loader #(
    parameter int unsigned ADDR_W = mips_pkg::ADDR_W,
    parameter int unsigned DATA_W = mips_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              data_reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              abort,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              load_memory,
    output logic [ADDR_W-1:0] mem_addr_select,
    output logic [DATA_W-1:0] data_mem_input,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written
);
    import mips_pkg::*;

    loader_state_t     state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   target;
    logic [ADDR_W:0]   ww_next_c;
    logic [DATA_W-1:0] word_next_c;
    logic              last_c;
    logic              accept_c;
    logic              clear_c;

    // Abort gates the handshake and the strobe in the same cycle it is seen.
    assign byte_ready  = (state == COLLECT) && !abort;
    assign load_memory = (state == WRITE) && !abort;
    assign busy        = (state != IDLE);
    assign accept_c    = byte_valid && byte_ready;
    assign ww_next_c   = words_written + (ADDR_W + 1)'(1);
    assign clear_c     = ((state == IDLE) && start)
                       || (abort && ((state == COLLECT) || (state == WRITE)));

    byte_packer #(.DATA_W(DATA_W)) u_packer (
        .clk         (clk),
        .rst_n       (data_reset_n),
        .clear       (clear_c),
        .accept      (accept_c),
        .byte_data   (byte_data),
        .word_next_c (word_next_c),
        .last_c      (last_c)
    );

    always_ff @(posedge clk or negedge data_reset_n) begin
        if (!data_reset_n) begin
            state           <= IDLE;
            addr            <= '0;
            target          <= '0;
            mem_addr_select <= '0;
            data_mem_input  <= '0;
            done            <= 1'b0;
            words_written   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        target        <= word_count;
                        words_written <= '0;
                        addr          <= base_addr;
                        state         <= (word_count == '0) ? DONE : COLLECT;
                    end
                end
                COLLECT: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (accept_c && last_c) begin
                        mem_addr_select <= addr;
                        data_mem_input  <= word_next_c;
                        state           <= WRITE;
                    end
                end
                WRITE: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        words_written <= ww_next_c;
                        addr          <= addr + ADDR_W'(1);
                        state         <= (ww_next_c == target) ? DONE : COLLECT;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_loader.sv
// Directed bench for data_mem_loader with a transaction-level reference model checked every cycle.
module tb_data_mem_loader;

    logic        clk = 1'b0;
    logic        data_reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [8:0]  word_count = '0;
    logic        abort = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready;
    logic        load_memory;
    logic [7:0]  mem_addr_select;
    logic [31:0] data_mem_input;
    logic        busy;
    logic        done;
    logic [8:0]  words_written;

    int checks = 0;
    int failures = 0;

    data_mem_loader dut (
        .clk             (clk),
        .data_reset_n    (data_reset_n),
        .start           (start),
        .base_addr       (base_addr),
        .word_count      (word_count),
        .abort           (abort),
        .byte_valid      (byte_valid),
        .byte_data       (byte_data),
        .byte_ready      (byte_ready),
        .load_memory     (load_memory),
        .mem_addr_select (mem_addr_select),
        .data_mem_input  (data_mem_input),
        .busy            (busy),
        .done            (done),
        .words_written   (words_written)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: burst bookkeeping with a byte queue, one step per clock.
    bit         m_collect = 0, m_write = 0, m_finish = 0, m_done = 0;
    logic [7:0] m_addr = '0, m_wr_addr = '0;
    logic [31:0] m_wr_data = '0;
    int         m_ww = 0, m_target = 0;
    logic [7:0] mq[$];

    always @(posedge clk or negedge data_reset_n) begin
        if (!data_reset_n) begin
            m_collect = 0; m_write = 0; m_finish = 0; m_done = 0;
            m_addr = '0; m_wr_addr = '0; m_wr_data = '0; m_ww = 0; m_target = 0;
            mq.delete();
        end else begin
            bit nd;
            nd = 0;
            if (m_finish) begin
                m_finish = 0;
                nd = 1;
            end else if (m_write) begin
                m_write = 0;
                if (!abort) begin
                    m_ww++;
                    m_addr = m_addr + 8'd1;
                    if (m_ww == m_target) m_finish = 1;
                    else m_collect = 1;
                end
            end else if (m_collect) begin
                if (abort) begin
                    m_collect = 0;
                    mq.delete();
                end else if (byte_valid) begin
                    mq.push_back(byte_data);
                    if (mq.size() == 4) begin
                        m_wr_data = {mq[3], mq[2], mq[1], mq[0]};
                        m_wr_addr = m_addr;
                        mq.delete();
                        m_collect = 0;
                        m_write = 1;
                    end
                end
            end else if (start) begin
                m_target = int'(word_count);
                m_ww = 0;
                if (word_count == 0) m_finish = 1;
                else begin
                    m_collect = 1;
                    m_addr = base_addr;
                    mq.delete();
                end
            end
            m_done = nd;
        end
    end

    // Per-cycle comparison plus a log of observed writes and done pulses.
    logic [39:0] act_log[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        chk("byte_ready", 64'(byte_ready), 64'(m_collect && !abort));
        chk("load_memory", 64'(load_memory), 64'(m_write && !abort));
        chk("mem_addr_select", 64'(mem_addr_select), 64'(m_wr_addr));
        chk("data_mem_input", 64'(data_mem_input), 64'(m_wr_data));
        chk("busy", 64'(busy), 64'(m_collect || m_write || m_finish));
        chk("done", 64'(done), 64'(m_done));
        chk("words_written", 64'(words_written), 64'(m_ww));
        if (load_memory) act_log.push_back({mem_addr_select, data_mem_input});
        if (done) done_cnt++;
    end

    logic [7:0] tx [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] b, input logic [8:0] n);
        start = 1'b1; base_addr = b; word_count = n;
        tick();
        start = 1'b0;
    endtask

    // Sends n bytes from tx honouring byte_ready; optional idle gap and a stray start pulse.
    task automatic send_bytes(input int n, input bit gap, input int start_at);
        for (int i = 0; i < n; i++) begin
            int w;
            byte_valid = 1'b1;
            byte_data  = tx[i];
            if (i == start_at) begin
                start = 1'b1; base_addr = 8'h55; word_count = 9'd5;
            end
            w = 0;
            while (!byte_ready && w < 20) begin
                tick();
                start = 1'b0;
                w++;
            end
            if (w == 20) chk("byte_ready_timeout", 64'(0), 64'(1));
            tick();
            start = 1'b0;
            byte_valid = 1'b0;
            if (gap) tick();
        end
    endtask

    task automatic wait_done(input string name);
        int c;
        c = 0;
        @(negedge clk);
        while (!done && c < 12) begin
            @(negedge clk);
            c++;
        end
        chk(name, 64'(done), 64'(1));
        #1;
    endtask

    initial begin
        int dc;
        // Reset state
        #12;
        chk("rst_load_memory", 64'(load_memory), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ready", 64'(byte_ready), 64'(0));
        chk("rst_words_written", 64'(words_written), 64'(0));
        data_reset_n = 1'b1;
        tick(); tick();

        // Two-word burst, back-to-back bytes
        tx = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        act_log.delete();
        do_start(8'h10, 9'd2);
        send_bytes(8, 1'b0, -1);
        wait_done("t1_done");
        chk("t1_nwrites", 64'(act_log.size()), 64'(2));
        if (act_log.size() == 2) begin
            chk("t1_w0", 64'(act_log[0]), 64'h10_4433_2211);
            chk("t1_w1", 64'(act_log[1]), 64'h11_8877_6655);
        end
        chk("t1_ww", 64'(words_written), 64'(2));
        tick(); tick();

        // Address wrap-around
        tx = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
        act_log.delete();
        do_start(8'hFF, 9'd2);
        send_bytes(8, 1'b0, -1);
        wait_done("t2_done");
        chk("t2_nwrites", 64'(act_log.size()), 64'(2));
        if (act_log.size() == 2) begin
            chk("t2_w0", 64'(act_log[0]), 64'hFF_A3A2_A1A0);
            chk("t2_w1", 64'(act_log[1]), 64'h00_B3B2_B1B0);
        end
        tick(); tick();

        // Zero-length burst: done two cycles after start, no write
        act_log.delete();
        do_start(8'h40, 9'd0);
        @(negedge clk);
        chk("t3_done_early", 64'(done), 64'(0));
        chk("t3_busy", 64'(busy), 64'(1));
        @(negedge clk);
        chk("t3_done", 64'(done), 64'(1));
        chk("t3_ww", 64'(words_written), 64'(0));
        #1;
        tick();
        chk("t3_nwrites", 64'(act_log.size()), 64'(0));
        tick();

        // Abort mid-word
        act_log.delete();
        dc = done_cnt;
        tx = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00};
        do_start(8'h20, 9'd1);
        send_bytes(2, 1'b0, -1);
        abort = 1'b1; byte_valid = 1'b1; byte_data = 8'hC2;
        #1;
        chk("t4_ready_abort", 64'(byte_ready), 64'(0));
        tick();
        abort = 1'b0; byte_valid = 1'b0;
        chk("t4_busy", 64'(busy), 64'(0));
        for (int i = 0; i < 5; i++) tick();
        chk("t4_nwrites", 64'(act_log.size()), 64'(0));
        chk("t4_no_done", 64'(done_cnt), 64'(dc));

        // Toggled byte_valid with a stray start mid-burst
        tx = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        act_log.delete();
        do_start(8'h10, 9'd2);
        send_bytes(8, 1'b1, 2);
        wait_done("t5_done");
        chk("t5_nwrites", 64'(act_log.size()), 64'(2));
        if (act_log.size() == 2) begin
            chk("t5_w0", 64'(act_log[0]), 64'h10_4433_2211);
            chk("t5_w1", 64'(act_log[1]), 64'h11_8877_6655);
        end
        chk("t5_ww", 64'(words_written), 64'(2));
        tick(); tick();

        // Reset asserted during WRITE
        tx = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'h00, 8'h00, 8'h00, 8'h00};
        act_log.delete();
        do_start(8'h30, 9'd1);
        send_bytes(4, 1'b0, -1);
        chk("t6_load_before", 64'(load_memory), 64'(1));
        #2;
        data_reset_n = 1'b0;
        #1;
        chk("t6_load_dropped", 64'(load_memory), 64'(0));
        chk("t6_busy", 64'(busy), 64'(0));
        chk("t6_addr", 64'(mem_addr_select), 64'(0));
        chk("t6_data", 64'(data_mem_input), 64'(0));
        chk("t6_ww", 64'(words_written), 64'(0));
        @(negedge clk); @(negedge clk);
        #1;
        data_reset_n = 1'b1;
        act_log.delete();
        for (int i = 0; i < 4; i++) tick();
        chk("t6_nwrites_after", 64'(act_log.size()), 64'(0));
        chk("t6_done_after", 64'(done), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
